// File: rtl/hms_display_scan.sv
// ---------------------------------------------------------------------------
// hms_display_scan
//
// Multiplexed 6-digit 7-segment driver for an hh:mm:ss time value.
// It captures hours/minutes/seconds on `load`, converts them to BCD in a
// staging register, and copies that register into the display buffer only
// when the scan wraps from digit 5 back to digit 0. A frame therefore never
// mixes digits from two different loads. Each digit slot starts with a short
// all-off interval to stop ghosting on the shared segment bus.
//
// Parameters
//   DWELL_W     slot counter width; each digit slot lasts 2^DWELL_W cycles
//   BLANK_CYC   all-off cycles at the start of each slot (< 2^DWELL_W)
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous, active-low reset
//   load         in   capture strobe for hours/minutes/seconds
//   hours        in   5-bit binary, 0..23 valid
//   minutes      in   6-bit binary, 0..59 valid
//   seconds      in   6-bit binary, 0..59 valid
//   number       out  segment bus, active-low, bit 7 = dp, bits 6:0 = g..a
//   digit_block  out  digit enables, active-low one-hot,
//                     bit 0 = seconds ones, bit 5 = hours tens
//
// Build option
//   DISPLAY_DP_SEP_EN  when defined, the dp of digits 2 and 4 is lit while
//                      the buffered seconds value is even (1 Hz separator).
//                      When undefined, dp is always off.
//
// Scan states (decoded from the slot counter each cycle)
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_BLANK | cnt < BLANK_CYC: all digits off, segment bus all ones
//   ST_DRIVE | cnt >= BLANK_CYC: enable digit idx, drive its segment code
// ---------------------------------------------------------------------------
module hms_display_scan #(
  parameter int DWELL_W   = 13,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  output logic [7:0] number,
  output logic [5:0] digit_block
);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  localparam logic [3:0]         DASH      = 4'hA;
  localparam logic [DWELL_W-1:0] BLANK_LIM = DWELL_W'(BLANK_CYC);
  localparam logic [DWELL_W-1:0] CNT_MAX   = '1;
  localparam logic [2:0]         IDX_LAST  = 3'd5;

  // -------------------------------------------------------------------------
  // Binary (0..63) to two BCD digits. Anything above max_v shows as dashes so
  // a bad field is visibly wrong instead of silently wrapping.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] to_bcd(input logic [5:0] v, input logic [5:0] max_v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v > max_v) begin
      tens = DASH;
      ones = DASH;
    end else if (v >= 6'd50) begin
      tens = 4'd5;
      ones = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      ones = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      ones = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      ones = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      ones = 4'(v - 6'd10);
    end else begin
      tens = 4'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  // Active-low segment code, dp off.
  function automatic logic [7:0] seg_code(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // -------------------------------------------------------------------------
  // Snapshot: last load before a frame boundary wins.
  // -------------------------------------------------------------------------
  logic [4:0] snap_h;
  logic [5:0] snap_m;
  logic [5:0] snap_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_h <= '0;
      snap_m <= '0;
      snap_s <= '0;
    end else if (load) begin
      snap_h <= hours;
      snap_m <= minutes;
      snap_s <= seconds;
    end
  end

  // -------------------------------------------------------------------------
  // Staging: BCD of the snapshot, refreshed every cycle.
  // Nibble n holds display digit n (nibble 0 = seconds ones).
  // -------------------------------------------------------------------------
  logic [7:0]  bcd_h;
  logic [7:0]  bcd_m;
  logic [7:0]  bcd_s;
  logic [23:0] stage_d;

  always_comb begin
    bcd_h = to_bcd({1'b0, snap_h}, 6'd23);
    bcd_m = to_bcd(snap_m, 6'd59);
    bcd_s = to_bcd(snap_s, 6'd59);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_d <= '0;
    end else begin
      stage_d <= {bcd_h, bcd_m, bcd_s};
    end
  end

  // -------------------------------------------------------------------------
  // Scan counters.
  // -------------------------------------------------------------------------
  logic [DWELL_W-1:0] cnt;
  logic [2:0]         idx;
  logic               slot_end;
  logic               frame_end;

  always_comb begin
    slot_end  = (cnt == CNT_MAX);
    frame_end = slot_end && (idx == IDX_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Display buffer: swapped only on the 5 -> 0 wrap. A load landing on that
  // same edge is still in the snapshot, so it waits one more frame.
  // -------------------------------------------------------------------------
  logic [23:0] disp_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_d <= '0;
    end else if (frame_end) begin
      disp_d <= stage_d;
    end
  end

`ifdef DISPLAY_DP_SEP_EN
  // Seconds parity follows the same snapshot -> staging -> buffer path as
  // the digits so the separator blinks in step with the displayed seconds.
  logic stage_even;
  logic disp_even;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_even <= 1'b1;
      disp_even  <= 1'b1;
    end else begin
      stage_even <= ~snap_s[0];
      if (frame_end) begin
        disp_even <= stage_even;
      end
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Per-slot decode.
  // -------------------------------------------------------------------------
  logic [0:0] state;
  logic [3:0] cur_digit;
  logic [7:0] seg_now;
  logic       dp_n;

  always_comb begin
    state = (cnt < BLANK_LIM) ? ST_BLANK : ST_DRIVE;

    case (idx)
      3'd0:    cur_digit = disp_d[3:0];
      3'd1:    cur_digit = disp_d[7:4];
      3'd2:    cur_digit = disp_d[11:8];
      3'd3:    cur_digit = disp_d[15:12];
      3'd4:    cur_digit = disp_d[19:16];
      3'd5:    cur_digit = disp_d[23:20];
      default: cur_digit = DASH;
    endcase

    seg_now = seg_code(cur_digit);

`ifdef DISPLAY_DP_SEP_EN
    dp_n = ~(disp_even && ((idx == 3'd2) || (idx == 3'd4)));
`else
    dp_n = 1'b1;
`endif
  end

  // -------------------------------------------------------------------------
  // Registered outputs; async reset blanks the display immediately.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      number      <= 8'hFF;
      digit_block <= 6'h3F;
    end else if (state == ST_BLANK) begin
      number      <= 8'hFF;
      digit_block <= 6'h3F;
    end else begin
      number      <= seg_now & {dp_n, 7'h7F};
      digit_block <= ~(6'b000001 << idx);
    end
  end

endmodule

// File: tb/tb_hms_display_scan.sv
// ---------------------------------------------------------------------------
// tb_hms_display_scan
//
// Directed bench for hms_display_scan with DWELL_W=4 (16-cycle slots,
// 96-cycle frames) and BLANK_CYC=2. A free-running cycle count, cleared by
// rst, locates each sample inside the frame. Digit values per scenario are
// written out by hand; segment codes come from a fixed table.
// ---------------------------------------------------------------------------
module tb_hms_display_scan;

  localparam int SLOT  = 16;
  localparam int FRAME = 96;
  localparam int BLANK = 2;
  localparam int DASHV = 10;

`ifdef DISPLAY_DP_SEP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  localparam logic [7:0] SEG [11] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF};

  logic       clk;
  logic       rst;
  logic       load;
  logic [4:0] hours;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic [7:0] number;
  logic [5:0] digit_block;

  int checks;
  int failures;
  int tcyc;

  logic [5:0] obs_db  [6];
  logic [7:0] obs_num [6];
  int         obs_bad;

  hms_display_scan #(
    .DWELL_W   (4),
    .BLANK_CYC (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .hours       (hours),
    .minutes     (minutes),
    .seconds     (seconds),
    .number      (number),
    .digit_block (digit_block)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) tcyc <= 0;
    else      tcyc <= tcyc + 1;
  end

  function automatic logic [7:0] exp_code(input int d, input int slot, input bit even);
    logic [7:0] c;
    c = SEG[d];
    if (DP_EN && even && (slot == 2 || slot == 4)) c[7] = 1'b0;
    return c;
  endfunction

  function automatic logic [5:0] exp_en(input int slot);
    logic [5:0] one;
    one = 6'd1;
    return ~(one << slot);
  endfunction

  task automatic wait_mod(input int m);
    int k;
    k = 0;
    while ((tcyc % FRAME) != m && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300) begin
      failures++;
      $display("FAIL wait_mod timeout: tcyc=%0d wanted phase %0d", tcyc, m);
    end
  endtask

  task automatic pulse_load(input int h, input int m, input int s);
    hours   = 5'(h);
    minutes = 6'(m);
    seconds = 6'(s);
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;
  endtask

  // Records one whole frame starting at the next boundary; per-slot values
  // are taken at the first DRIVE cycle, and any blanking violation, two-hot
  // enable or mid-slot change is counted in obs_bad.
  task automatic capture_frame();
    int k;
    int c;
    int s;
    k = 0;
    while (!((tcyc % FRAME) == 0 && tcyc != 0) && k < 300) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 300) begin
      failures++;
      $display("FAIL frame_sync timeout: tcyc=%0d", tcyc);
    end
    obs_bad = 0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      c = j % SLOT;
      s = j / SLOT;
      if (c < BLANK) begin
        if (digit_block !== 6'h3F || number !== 8'hFF) obs_bad++;
      end else begin
        if (c == BLANK) begin
          obs_db[s]  = digit_block;
          obs_num[s] = number;
        end else if (digit_block !== obs_db[s] || number !== obs_num[s]) begin
          obs_bad++;
        end
        if ($countones(~digit_block) != 1) obs_bad++;
      end
    end
  endtask

  task automatic test_reset();
    int p, c, s;
    logic [5:0] edb;
    logic [7:0] enm;
    rst = 1'b0;
    load = 1'b0;
    hours = '0;
    minutes = '0;
    seconds = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (number !== 8'hFF) begin
      failures++;
      $display("FAIL reset_number: got %h want ff", number);
    end
    checks++;
    if (digit_block !== 6'h3F) begin
      failures++;
      $display("FAIL reset_digit: got %b want 111111", digit_block);
    end
    rst = 1'b1;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      p = j - 1;
      c = p % SLOT;
      s = p / SLOT;
      if (c < BLANK) begin
        edb = 6'h3F;
        enm = 8'hFF;
      end else begin
        edb = exp_en(s);
        enm = exp_code(0, s, 1'b1);
      end
      checks++;
      if (digit_block !== edb) begin
        failures++;
        $display("FAIL reset_scan_digit cyc=%0d: got %b want %b", j, digit_block, edb);
      end
      checks++;
      if (number !== enm) begin
        failures++;
        $display("FAIL reset_scan_number cyc=%0d: got %h want %h", j, number, enm);
      end
    end
  endtask

  // Load lands on the boundary edge: one frame of old digits, then new.
  task automatic test_load_boundary();
    int ed[6];
    wait_mod(FRAME - 1);
    pulse_load(12, 34, 56);
    capture_frame();
    checks++;
    if (obs_bad !== 0) begin
      failures++;
      $display("FAIL load_old_frame_scan: bad=%0d want 0", obs_bad);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_num[i] !== exp_code(0, i, 1'b1) || obs_db[i] !== exp_en(i)) begin
        failures++;
        $display("FAIL load_old_frame slot%0d: got %h/%b want %h/%b", i, obs_num[i], obs_db[i],
                 exp_code(0, i, 1'b1), exp_en(i));
      end
    end
    ed = '{6, 5, 4, 3, 2, 1};
    capture_frame();
    checks++;
    if (obs_bad !== 0) begin
      failures++;
      $display("FAIL load_new_frame_scan: bad=%0d want 0", obs_bad);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_num[i] !== exp_code(ed[i], i, 1'b1) || obs_db[i] !== exp_en(i)) begin
        failures++;
        $display("FAIL load_12_34_56 slot%0d: got %h/%b want %h/%b", i, obs_num[i], obs_db[i],
                 exp_code(ed[i], i, 1'b1), exp_en(i));
      end
    end
  endtask

  task automatic test_out_of_range();
    int ed[6];
    wait_mod(40);
    pulse_load(24, 7, 60);
    ed = '{DASHV, DASHV, 7, 0, DASHV, DASHV};
    capture_frame();
    checks++;
    if (obs_bad !== 0) begin
      failures++;
      $display("FAIL range_scan: bad=%0d want 0", obs_bad);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_num[i] !== exp_code(ed[i], i, 1'b1)) begin
        failures++;
        $display("FAIL range_24_07_60 slot%0d: got %h want %h", i, obs_num[i], exp_code(ed[i], i, 1'b1));
      end
    end
  endtask

  task automatic test_back_to_back();
    int ed[6];
    wait_mod(10);
    pulse_load(1, 2, 3);
    wait_mod(50);
    pulse_load(4, 5, 6);
    ed = '{6, 0, 5, 0, 4, 0};
    capture_frame();
    checks++;
    if (obs_bad !== 0) begin
      failures++;
      $display("FAIL double_scan: bad=%0d want 0", obs_bad);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_num[i] !== exp_code(ed[i], i, 1'b1) || obs_db[i] !== exp_en(i)) begin
        failures++;
        $display("FAIL double_04_05_06 slot%0d: got %h/%b want %h/%b", i, obs_num[i], obs_db[i],
                 exp_code(ed[i], i, 1'b1), exp_en(i));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] edb;
    logic [7:0] enm;
    // Phase 57 is slot 3, eighth cycle: well inside DRIVE.
    wait_mod(57);
    checks++;
    if (digit_block !== 6'b110111 || number !== exp_code(0, 3, 1'b1)) begin
      failures++;
      $display("FAIL midrst_pre slot3: got %h/%b want %h/110111", number, digit_block, exp_code(0, 3, 1'b1));
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (digit_block !== 6'h3F || number !== 8'hFF) begin
      failures++;
      $display("FAIL midrst_async_blank: got %h/%b want ff/111111", number, digit_block);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      edb = (j < 3) ? 6'h3F : 6'b111110;
      enm = (j < 3) ? 8'hFF : exp_code(0, 0, 1'b1);
      checks++;
      if (digit_block !== edb || number !== enm) begin
        failures++;
        $display("FAIL midrst_restart cyc=%0d: got %h/%b want %h/%b", j, number, digit_block, enm, edb);
      end
    end
    capture_frame();
    checks++;
    if (obs_bad !== 0) begin
      failures++;
      $display("FAIL midrst_scan: bad=%0d want 0", obs_bad);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (obs_num[i] !== exp_code(0, i, 1'b1) || obs_db[i] !== exp_en(i)) begin
        failures++;
        $display("FAIL midrst_zero slot%0d: got %h/%b want %h/%b", i, obs_num[i], obs_db[i],
                 exp_code(0, i, 1'b1), exp_en(i));
      end
    end
  endtask

  task automatic test_dp_sep();
    int ed[6];
    logic [7:0] e;
    wait_mod(20);
    pulse_load(9, 30, 42);
    ed = '{2, 4, 0, 3, 9, 0};
    capture_frame();
    for (int i = 0; i < 6; i++) begin
      e = exp_code(ed[i], i, 1'b1);
      checks++;
      if (obs_num[i] !== e) begin
        failures++;
        $display("FAIL dp_even_42 slot%0d: got %h want %h", i, obs_num[i], e);
      end
    end
    wait_mod(20);
    pulse_load(9, 30, 43);
    ed = '{3, 4, 0, 3, 9, 0};
    capture_frame();
    for (int i = 0; i < 6; i++) begin
      e = exp_code(ed[i], i, 1'b0);
      checks++;
      if (obs_num[i] !== e || obs_num[i][7] !== 1'b1) begin
        failures++;
        $display("FAIL dp_odd_43 slot%0d: got %h want %h", i, obs_num[i], e);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    load = 1'b0;
    hours = '0;
    minutes = '0;
    seconds = '0;
    test_reset();
    test_load_boundary();
    test_out_of_range();
    test_back_to_back();
    test_mid_reset();
    test_dp_sep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
